// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads IMG_W x IMG_H pixels from IROM, edits a 2x2 window on host command, streams the buffer to IRAM.
// Commands are taken only while busy=0; LCD_RELOAD_EN turns cmd 12 into a full IROM reload.
module lcd_win_ctrl #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0]     X_RST = XW'(IMG_W / 2 - 1);
  localparam logic [YW-1:0]     Y_RST = YW'(IMG_H / 2 - 1);
  localparam logic [XW-1:0]     X_MAX = XW'(IMG_W - 2);
  localparam logic [YW-1:0]     Y_MAX = YW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   pix_mem [N];
  logic [XW-1:0]       win_x;
  logic [YW-1:0]       win_y;
  logic [3:0]          cmd_q;
  logic                cap_vld;
  logic [ADDR_W-1:0]   cap_a;
  logic [ADDR_W-1:0]   wr_cnt;
  logic                reload;
  logic [ADDR_W-1:0]   idx_tl, idx_tr, idx_bl, idx_br;
  logic [DATA_W-1:0]   p_tl, p_tr, p_bl, p_br;
  logic [DATA_W-1:0]   n_tl, n_tr, n_bl, n_br;
  logic [DATA_W-1:0]   max_t, max_b, min_t, min_b, pmax, pmin;
  logic [DATA_W+1:0]   sum;
  logic                win_we;

`ifdef LCD_RELOAD_EN
  assign reload = (cmd_q == 4'd12);
`else
  assign reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_LOAD;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (cap_vld && cap_a == LAST) state_nxt = S_IDLE;
      S_IDLE:  if (cmd_valid) state_nxt = (cmd == 4'd0) ? S_WRITE : S_EXEC;
      S_EXEC:  state_nxt = reload ? S_LOAD : S_IDLE;
      S_WRITE: if (wr_cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    IRAM_valid = (state == S_WRITE);
    IRAM_A     = '0;
    IRAM_D     = '0;
    if (state == S_WRITE) begin
      IRAM_A = wr_cnt;
      IRAM_D = pix_mem[wr_cnt];
    end
  end

  // A load starts when neither a read is in flight nor a capture pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IROM_rd <= 1'b0;
      IROM_A  <= '0;
      cap_vld <= 1'b0;
      cap_a   <= '0;
      wr_cnt  <= '0;
      cmd_q   <= '0;
      win_x   <= X_RST;
      win_y   <= Y_RST;
    end else begin
      cap_vld <= IROM_rd;
      cap_a   <= IROM_A;
      if (state == S_LOAD) begin
        if (!IROM_rd && !cap_vld) begin
          IROM_rd <= 1'b1;
          IROM_A  <= '0;
        end else if (IROM_rd) begin
          if (IROM_A == LAST) IROM_rd <= 1'b0;
          else                IROM_A  <= IROM_A + ADDR_W'(1);
        end
      end
      wr_cnt <= (state == S_WRITE) ? wr_cnt + ADDR_W'(1) : '0;
      if (state == S_IDLE && cmd_valid) cmd_q <= cmd;
      if (state == S_EXEC) begin
        if (reload) begin
          win_x <= X_RST;
          win_y <= Y_RST;
        end else begin
          case (cmd_q)
            4'd1:    if (win_y != '0)    win_y <= win_y - YW'(1);
            4'd2:    if (win_y != Y_MAX) win_y <= win_y + YW'(1);
            4'd3:    if (win_x != '0)    win_x <= win_x - XW'(1);
            4'd4:    if (win_x != X_MAX) win_x <= win_x + XW'(1);
            default: ;
          endcase
        end
      end
    end
  end

  assign idx_tl = ADDR_W'(win_y) * ADDR_W'(IMG_W) + ADDR_W'(win_x);
  assign idx_tr = idx_tl + ADDR_W'(1);
  assign idx_bl = idx_tl + ADDR_W'(IMG_W);
  assign idx_br = idx_bl + ADDR_W'(1);
  assign p_tl   = pix_mem[idx_tl];
  assign p_tr   = pix_mem[idx_tr];
  assign p_bl   = pix_mem[idx_bl];
  assign p_br   = pix_mem[idx_br];

  always_comb begin
    max_t = (p_tl > p_tr) ? p_tl : p_tr;
    max_b = (p_bl > p_br) ? p_bl : p_br;
    min_t = (p_tl < p_tr) ? p_tl : p_tr;
    min_b = (p_bl < p_br) ? p_bl : p_br;
    pmax  = (max_t > max_b) ? max_t : max_b;
    pmin  = (min_t < min_b) ? min_t : min_b;
    sum   = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
  end

  always_comb begin
    win_we = (state == S_EXEC);
    n_tl   = p_tl;
    n_tr   = p_tr;
    n_bl   = p_bl;
    n_br   = p_br;
    case (cmd_q)
      4'd5:  begin n_tl = pmax; n_tr = pmax; n_bl = pmax; n_br = pmax; end
      4'd6:  begin n_tl = pmin; n_tr = pmin; n_bl = pmin; n_br = pmin; end
      4'd7:  begin
        n_tl = sum[DATA_W+1:2];
        n_tr = sum[DATA_W+1:2];
        n_bl = sum[DATA_W+1:2];
        n_br = sum[DATA_W+1:2];
      end
      4'd8:  begin n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl; end
      4'd9:  begin n_tl = p_bl; n_tr = p_tl; n_br = p_tr; n_bl = p_br; end
      4'd10: begin n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr; end
      4'd11: begin n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl; end
      default: win_we = 1'b0;
    endcase
  end

  // Pixel store has no reset; its contents are undefined until the first load.
  always_ff @(posedge clk) begin
    if (cap_vld) begin
      pix_mem[cap_a] <= IROM_Q;
    end else if (win_we) begin
      pix_mem[idx_tl] <= n_tl;
      pix_mem[idx_tr] <= n_tr;
      pix_mem[idx_bl] <= n_bl;
      pix_mem[idx_br] <= n_br;
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Self-checking bench for lcd_win_ctrl: directed vector table, reset-during-write sequence, random commands against a window model.
module tb_lcd_win_ctrl;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  lcd_win_ctrl #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(IROM_Q), .IROM_rd(IROM_rd), .IROM_A(IROM_A),
    .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ROM returns data the cycle after the address is presented.
  logic [DW-1:0] rom [N];
  always @(posedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];

  logic [DW-1:0] ram [N];
  int wr_seen = 0, done_seen = 0, addr_err = 0, excl_err = 0, burst = 0;
  bit prev_vld = 1'b0;
  always @(negedge clk) begin
    if (IROM_rd && IRAM_valid) excl_err++;
    if (IRAM_valid) begin
      if (!prev_vld) burst = 0;
      if (int'(IRAM_A) != burst) addr_err++;
      ram[IRAM_A] = IRAM_D;
      wr_seen++;
      burst++;
    end
    prev_vld = IRAM_valid;
    if (done) done_seen++;
  end

  // Reference model: image array plus window origin.
  int m_img [N];
  int mx, my;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_img[i] = int'(rom[i]);
    mx = W / 2 - 1;
    my = H / 2 - 1;
  endfunction

  function automatic void model_cmd(input int c);
    int ring [4];
    int v [4];
    int nv [4];
    int mxv, mnv, s;
    ring[0] = my * W + mx;         // TL
    ring[1] = my * W + mx + 1;     // TR
    ring[2] = (my + 1) * W + mx + 1; // BR
    ring[3] = (my + 1) * W + mx;   // BL
    for (int k = 0; k < 4; k++) v[k] = m_img[ring[k]];
    mxv = v[0]; mnv = v[0]; s = 0;
    for (int k = 0; k < 4; k++) begin
      if (v[k] > mxv) mxv = v[k];
      if (v[k] < mnv) mnv = v[k];
      s += v[k];
    end
    for (int k = 0; k < 4; k++) nv[k] = v[k];
    case (c)
      1: if (my > 0) my--;
      2: if (my < H - 2) my++;
      3: if (mx > 0) mx--;
      4: if (mx < W - 2) mx++;
      5: for (int k = 0; k < 4; k++) nv[k] = mxv;
      6: for (int k = 0; k < 4; k++) nv[k] = mnv;
      7: for (int k = 0; k < 4; k++) nv[k] = s / 4;
      8: for (int k = 0; k < 4; k++) nv[k] = v[(k + 1) % 4];
      9: for (int k = 0; k < 4; k++) nv[k] = v[(k + 3) % 4];
      10: for (int k = 0; k < 4; k++) nv[k] = v[3 - k];
      11: for (int k = 0; k < 4; k++) nv[k] = v[k ^ 1];
`ifdef LCD_RELOAD_EN
      12: model_reset();
`endif
      default: ;
    endcase
    if (c >= 5 && c <= 11)
      for (int k = 0; k < 4; k++) m_img[ring[k]] = nv[k];
  endfunction

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  task automatic do_reset();
    int cyc = 0;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_IROM_rd", IROM_rd, 0);
    check("rst_IROM_A", IROM_A, 0);
    check("rst_IRAM_valid", IRAM_valid, 0);
    check("rst_IRAM_D", IRAM_D, 0);
    check("rst_IRAM_A", IRAM_A, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    model_reset();
    reset_n = 1'b1;
    while (busy === 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("load_cycles_to_idle", cyc, N + 2);
  endtask

  task automatic issue(input logic [3:0] c, input bit junk);
    bit is_exec;
    is_exec = (c != 4'd0);
`ifdef LCD_RELOAD_EN
    if (c == 4'd12) is_exec = 1'b0;
`endif
    wait_idle(300);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    model_cmd(int'(c));
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    if (junk) begin
      cmd = 4'($urandom_range(0, 15));
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    @(negedge clk);
    if (is_exec) check("exec_one_cycle", busy, 0);
  endtask

  task automatic do_write(input bit junk);
    int w0, d0, a0, bad;
    w0 = wr_seen; d0 = done_seen; a0 = addr_err; bad = 0;
    issue(4'd0, junk);
    wait_idle(300);
    check("write_count", wr_seen - w0, N);
    check("done_pulses", done_seen - d0, 1);
    check("write_addr_order", addr_err - a0, 0);
    for (int i = 0; i < N; i++) if (int'(ram[i]) !== m_img[i]) bad++;
    check("ram_vs_model_mismatches", bad, 0);
  endtask

  typedef struct {
    logic [39:0]      pre;  // commands, first one in the highest used nibble
    int               n;
    logic [3:0][7:0]  idx;
    logic [3:0][7:0]  val;
  } vec_t;

  vec_t vt [12];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{40'h0,          0,  {8'd0,  8'd27, 8'd36, 8'd63}, {8'd0,  8'd27, 8'd36, 8'd63}};
    vt[1]  = '{40'h5,          1,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd36, 8'd36, 8'd36, 8'd36}};
    vt[2]  = '{40'h7,          1,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd31, 8'd31, 8'd31, 8'd31}};
    vt[3]  = '{40'h6,          1,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd27, 8'd27, 8'd27, 8'd27}};
    vt[4]  = '{40'h9,          1,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd35, 8'd27, 8'd36, 8'd28}};
    vt[5]  = '{40'h98,         2,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd27, 8'd28, 8'd35, 8'd36}};
    vt[6]  = '{40'h111115,     6,  {8'd3,  8'd4,  8'd11, 8'd12}, {8'd12, 8'd12, 8'd12, 8'd12}};
    vt[7]  = '{40'h444445,     6,  {8'd30, 8'd31, 8'd38, 8'd39}, {8'd39, 8'd39, 8'd39, 8'd39}};
    vt[8]  = '{40'hA,          1,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd35, 8'd36, 8'd27, 8'd28}};
    vt[9]  = '{40'hB,          1,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd28, 8'd27, 8'd36, 8'd35}};
    vt[10] = '{40'h2222233336, 10, {8'd48, 8'd49, 8'd56, 8'd57}, {8'd48, 8'd48, 8'd48, 8'd48}};
`ifdef LCD_RELOAD_EN
    vt[11] = '{40'h5CDEF,      5,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd27, 8'd28, 8'd35, 8'd36}};
`else
    vt[11] = '{40'h5CDEF,      5,  {8'd27, 8'd28, 8'd35, 8'd36}, {8'd36, 8'd36, 8'd36, 8'd36}};
`endif

    for (int i = 0; i < N; i++) rom[i] = DW'(i);
    for (int k = 0; k < 12; k++) begin
      do_reset();
      for (int j = 0; j < vt[k].n; j++)
        issue(vt[k].pre[4 * (vt[k].n - 1 - j) +: 4], (j % 2) == 1);
      do_write(k[0]);
      for (int c = 0; c < 4; c++)
        check($sformatf("vec%0d_cell%0d", k, vt[k].idx[c]), ram[vt[k].idx[c]], vt[k].val[c]);
    end

    // Reset asserted mid write-back, then a clean reload and write.
    do_reset();
    issue(4'd5, 1'b0);
    issue(4'd0, 1'b0);
    begin
      int k = 0;
      while (!(IRAM_valid === 1'b1 && IRAM_A === AW'(20)) && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("reached_IRAM_A_20", IRAM_A, 20);
    end
    reset_n = 1'b0;
    #1;
    check("midwr_rst_IRAM_valid", IRAM_valid, 0);
    check("midwr_rst_IRAM_A", IRAM_A, 0);
    check("midwr_rst_IRAM_D", IRAM_D, 0);
    check("midwr_rst_IROM_rd", IROM_rd, 0);
    check("midwr_rst_IROM_A", IROM_A, 0);
    check("midwr_rst_busy", busy, 1);
    check("midwr_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reload_first_rd", IROM_rd, 1);
    check("reload_first_addr", IROM_A, 0);
    @(negedge clk);
    check("reload_second_addr", IROM_A, 1);
    model_reset();
    wait_idle(300);
    do_write(1'b0);

    // Random images and command streams.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) rom[i] = DW'($urandom_range(0, 255));
      do_reset();
      for (int t = 0; t < 30; t++) begin
        int c;
        c = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
        if (c == 0) do_write($urandom_range(0, 1) == 1);
        else begin
          issue(4'(c), $urandom_range(0, 1) == 1);
          wait_idle(300);
        end
      end
      do_write(1'b1);
    end

    check("rd_and_valid_overlap", excl_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_win_ctrl.md
Name: lcd_win_ctrl

Overview:
Parametrised image-window controller for the LCD image-processing flow. It loads an IMG_W x IMG_H image from IROM into an internal buffer. It then applies host commands to a movable 2x2 operation window: shifts, max/min/average fills, rotations and mirrors. On the write command it streams the whole buffer to IRAM. It generalises the fixed 8x8 controller with parametrised size and pixel width, new rotate/mirror modes, and return-to-idle after write-back.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 8, image width in pixels (>=2)
IMG_H, 8, image height in pixels (>=2)
ADDR_W, 6, ROM/RAM address width; 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cmd  in  4  command code
cmd_valid  in  1  command strobe, sampled only when busy=0
IROM_Q  in  DATA_W  ROM data, valid the cycle after IROM_A
IROM_rd  out  1  ROM read enable
IROM_A  out  ADDR_W  ROM address
IRAM_valid  out  1  RAM write strobe
IRAM_D  out  DATA_W  RAM write data
IRAM_A  out  ADDR_W  RAM write address
busy  out  1  1 = commands ignored
done  out  1  one-cycle pulse after write-back completes

Behaviour:
- Reset (async, any state): FSM goes to LOAD. Output values: IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, busy=1, done=0. Window origin (x,y)=(IMG_W/2-1, IMG_H/2-1). Buffer contents undefined.
- Let N=IMG_W*IMG_H.
- Pixel index = y*IMG_W+x. Window cells: TL=(x,y), TR=(x+1,y), BL=(x,y+1), BR=(x+1,y+1).
- States: LOAD, IDLE, EXEC, WRITE, DONE.
- LOAD:
  - IROM_rd=1; IROM_A steps 0..N-1, one per cycle, then holds N-1.
  - Each IROM_Q is captured one cycle after its address.
  - After pixel N-1 is captured: IROM_rd=0, go to IDLE.
- IDLE: busy=0. When cmd_valid=1, latch cmd; next cycle busy=1.
  - cmd 0 -> WRITE.
  - Any other code -> EXEC.
- EXEC: exactly one cycle, then IDLE. Command codes:
  - 1 up: y-1, clamped at 0.
  - 2 down: y+1, clamped at IMG_H-2.
  - 3 left: x-1, clamped at 0.
  - 4 right: x+1, clamped at IMG_W-2.
  - 5 max: all 4 cells set to the max value.
  - 6 min: all 4 cells set to the min value.
  - 7 average: sum in DATA_W+2 bits, >>2, truncated; all 4 cells set to the result.
  - 8 rotate CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL.
  - 9 rotate CW: TL<=BL, TR<=TL, BR<=TR, BL<=BR.
  - 10 mirror X: TL<->BL, TR<->BR.
  - 11 mirror Y: TL<->TR, BL<->BR.
  - 12-15: no-op (see optional feature for 12).
- WRITE:
  - IRAM_valid=1 for exactly N consecutive cycles.
  - IRAM_A=0..N-1, with IRAM_D=buffer[IRAM_A] in the same cycle.
  - Then IRAM_valid=0 and go to DONE.
- DONE: done=1 for one cycle, busy=1. Then IDLE with busy=0; buffer and origin retained.
- cmd_valid while busy=1: ignored, no queuing.
- Simultaneous cmd_valid with the LOAD-to-IDLE transition: not sampled until busy=0 is visible.
- IROM_rd and IRAM_valid are never high together.

Optional Feature:
Macro LCD_RELOAD_EN.
- Defined: cmd 12 = reload. It resets the origin to the reset value, enters LOAD and re-reads IROM from address 0; busy stays 1 until the load finishes.
- Undefined: cmd 12 is a one-cycle no-op, like 13-15.

Test Plan:
- Defaults, IROM[i]=i; reset, then cmd 0 -> busy falls after 64 reads; IRAM gets 64 writes with IRAM_D==IRAM_A; done pulses once; busy=0 afterwards.
- cmd 5 (max) then cmd 0 -> IRAM[27],[28],[35],[36] = 36; all others unchanged.
- cmd 7 (average) -> cells 27,28,35,36 = 31 (126>>2); separately, cmd 6 (min) -> all four = 27.
- cmd 9 (rotate CW) -> [27]=35, [28]=27, [36]=28, [35]=36; cmd 8 afterwards restores the original values.
- Five cmd 1 then cmd 5 -> window TL index 3: cells 3,4,11,12 = 12. Five cmd 4 -> x clamps at 6.
- reset_n low during WRITE at IRAM_A=20 -> all outputs take reset values immediately; IROM reload restarts at address 0. With LCD_RELOAD_EN, cmd 12 after cmd 5 -> write-back shows the original image.
